// File: rtl/ram_banked_pkg.sv
// Shared constants, FSM state type and geometry helpers for the banked RAM.
package ram_banked_pkg;

    localparam int MACRO_WORDS = 1024;
    localparam int MACRO_W     = 32;
    localparam int MACRO_AW    = 10;

    typedef enum logic [1:0] {
        RST  = 2'd0,
        ZERO = 2'd1,
        IDLE = 2'd2
    } state_t;

    function automatic int lanes(input int data_w);
        return data_w / MACRO_W;
    endfunction

    function automatic int rows(input int depth);
        return depth / MACRO_WORDS;
    endfunction

endpackage

// File: rtl/ram_banked_row.sv
// One row of LANES 1024x32 macros sharing address/enable; lane L owns bytes 4L..4L+3.
module ram_banked_row
    import ram_banked_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic [LANES*4-1:0]         we,
    input  logic [MACRO_AW-1:0]        addr,
    input  logic [LANES*MACRO_W-1:0]   di,
    output logic [LANES*MACRO_W-1:0]   dout
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef USE_DFFRAM_BEH
        DFFRAM_beh #(.COLS(4)) u_mac (
            .CLK (clk),
            .WE  (we[4*l +: 4]),
            .EN  (en),
            .Di  (di[MACRO_W*l +: MACRO_W]),
            .Do  (dout[MACRO_W*l +: MACRO_W]),
            .A   (addr)
        );
`elsif USE_DFFRAM_4K
        DFFRAM_4K #(.COLS(4)) u_mac (
            .CLK (clk),
            .WE  (we[4*l +: 4]),
            .EN  (en),
            .Di  (di[MACRO_W*l +: MACRO_W]),
            .Do  (dout[MACRO_W*l +: MACRO_W]),
            .A   (addr)
        );
`else
        // Stand-in with the macro's timing: byte-enabled write, registered read of the old word.
        logic [MACRO_W-1:0] mem [MACRO_WORDS];
        logic [MACRO_W-1:0] dq;

        // Macro port: byte writes and synchronous read while enabled.
        always_ff @(posedge clk) begin
            if (en) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[4*l+b]) begin
                        mem[addr][8*b +: 8] <= di[MACRO_W*l + 8*b +: 8];
                    end
                end
                dq <= mem[addr];
            end
        end

        assign dout[MACRO_W*l +: MACRO_W] = dq;
`endif
    end

endmodule

// File: rtl/ram_banked_zinit.sv
// DATA_W x DEPTH RAM from 1024x32 macros with post-reset zero fill and READY/RVALID handshake.
//
//  state | meaning
//  RST   | held in / just out of reset, nothing accepted
//  ZERO  | zero-init engine clears macro address cnt in every row
//  IDLE  | READY=1, accesses accepted
module ram_banked_zinit
    import ram_banked_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int OUT_REG = 0,
    parameter int ZINIT   = 1
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       EN,
    input  logic [DATA_W/8-1:0]        WE,
    input  logic [$clog2(DEPTH)-1:0]   A,
    input  logic [DATA_W-1:0]          Di,
    output logic [DATA_W-1:0]          Do,
    output logic                       RVALID,
    output logic                       READY,
    output logic                       BUSY
);

    localparam int LANES = lanes(DATA_W);
    localparam int ROWS  = rows(DEPTH);
    localparam int AW    = $clog2(DEPTH);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WB    = DATA_W / 8;

    if ((DATA_W % MACRO_W) != 0 || DATA_W < 32 || DATA_W > 256) begin : g_bad_width
        $error("ram_banked_zinit: DATA_W=%0d must be a multiple of 32 in 32..256", DATA_W);
    end
    if ((DEPTH % MACRO_WORDS) != 0 || DEPTH < 1024 || DEPTH > 8192 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ram_banked_zinit: DEPTH=%0d must be a power of 2 in 1024..8192", DEPTH);
    end

    state_t                 state_q, state_d;
    logic [MACRO_AW-1:0]    cnt_q;
    logic                   busy_q, ready_q, rvalid1_q;
    logic [ROW_W-1:0]       row_sel, rd_row_q;
    logic                   acc, rd_acc;
    logic [ROWS-1:0]        row_en;
    logic [WB-1:0]          m_we;
    logic [MACRO_AW-1:0]    m_addr;
    logic [DATA_W-1:0]      m_di;
    logic [DATA_W-1:0]      row_dout [ROWS];
    logic [DATA_W-1:0]      rd_mux;

    if (ROWS > 1) begin : g_rowsel
        assign row_sel = A[AW-1:MACRO_AW];
    end else begin : g_onerow
        assign row_sel = '0;
    end

    // State register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= RST;
        else         state_q <= state_d;
    end

    // Next-state: leave RST on the first clock, finish ZERO after the last macro word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:     state_d = (ZINIT != 0) ? ZERO : IDLE;
            ZERO:    if (cnt_q == MACRO_AW'(MACRO_WORDS - 1)) state_d = IDLE;
            IDLE:    state_d = IDLE;
            default: state_d = RST;
        endcase
    end

    // Outputs to the macros: zero fill drives every row at once, otherwise only the addressed row.
    always_comb begin
        acc    = (state_q == IDLE) && EN;
        rd_acc = acc && (WE == '0);
        m_we   = WE;
        m_addr = A[MACRO_AW-1:0];
        m_di   = Di;
        row_en = '0;
        if (state_q == ZERO) begin
            m_we   = '1;
            m_addr = cnt_q;
            m_di   = '0;
            row_en = '1;
        end else if (acc) begin
            row_en[row_sel] = 1'b1;
        end
    end

    // Zero-fill address counter.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)               cnt_q <= '0;
        else if (state_q == ZERO)  cnt_q <= cnt_q + 1'b1;
    end

    // Registered status and read tracking; the row of a read is remembered for the return mux.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            rvalid1_q <= 1'b0;
            rd_row_q  <= '0;
        end else begin
            busy_q    <= (state_d == ZERO);
            ready_q   <= (state_d == IDLE);
            rvalid1_q <= rd_acc;
            if (rd_acc) rd_row_q <= row_sel;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        ram_banked_row #(.LANES(LANES)) u_row (
            .clk  (CLK),
            .en   (row_en[r]),
            .we   (m_we),
            .addr (m_addr),
            .di   (m_di),
            .dout (row_dout[r])
        );
    end

    assign rd_mux = row_dout[rd_row_q];

    if (OUT_REG != 0) begin : g_oreg
        logic                rvalid2_q;
        logic [DATA_W-1:0]   do_q;

        // Second pipeline stage; data holds until the next read returns.
        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                rvalid2_q <= 1'b0;
                do_q      <= '0;
            end else begin
                rvalid2_q <= rvalid1_q;
                if (rvalid1_q) do_q <= rd_mux;
            end
        end

        assign RVALID = rvalid2_q;
        assign Do     = do_q;
    end else begin : g_noreg
        // Macro output is already a register; mask it so Do reads zero outside a valid beat.
        assign RVALID = rvalid1_q;
        assign Do     = rvalid1_q ? rd_mux : '0;
    end

    assign READY = ready_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_ram_banked_zinit.sv
// Directed bench: zero-init timing, byte merges, row decode, streaming reads, reset mid-stream.
module tb_ram_banked_zinit;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4096;
    localparam int AW     = 12;
    localparam int WB     = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [WB-1:0]     we_s;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] dout;
    logic              rvalid, ready, busy;

    int n_chk  = 0;
    int n_pass = 0;

    ram_banked_zinit #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .OUT_REG (0),
        .ZINIT   (1)
    ) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .EN     (en),
        .WE     (we_s),
        .A      (addr),
        .Di     (di),
        .Do     (dout),
        .RVALID (rvalid),
        .READY  (ready),
        .BUSY   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WB-1:0] w, input logic [DATA_W-1:0] d);
        en = 1'b1; we_s = w; addr = a; di = d;
        tick();
        en = 1'b0; we_s = '0;
        chk("wr_no_rvalid", {63'd0, rvalid}, 64'd0);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DATA_W-1:0] exp);
        en = 1'b1; we_s = '0; addr = a;
        tick();
        en = 1'b0;
        chk({tag, "_rvalid"}, {63'd0, rvalid}, 64'd1);
        chk(tag, dout, exp);
    endtask

    // Pokes EN (alternating write of all-ones to A=7 and read) while the engine runs.
    task automatic wait_ready(output int cyc, output int bcyc, output bit rv_seen);
        cyc = 0; bcyc = 0; rv_seen = 1'b0;
        while (!ready && cyc < 2000) begin
            en   = 1'b1;
            we_s = cyc[0] ? 8'hFF : 8'h00;
            addr = 12'd7;
            di   = '1;
            tick();
            cyc++;
            if (busy)   bcyc++;
            if (rvalid) rv_seen = 1'b1;
        end
        en = 1'b0; we_s = '0;
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hF00D_0000_0000_0000 | (64'(i) * 64'h0000_1111_0101_0011);
    endfunction

    initial begin
        int cyc, bcyc, rv_cnt;
        bit rv_seen;

        rst_n = 1'b0; en = 1'b0; we_s = '0; addr = '0; di = '0;
        repeat (3) tick();
        chk("rst_ready",  {63'd0, ready},  64'd0);
        chk("rst_busy",   {63'd0, busy},   64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_do",     dout,            64'd0);

        rst_n = 1'b1;
        wait_ready(cyc, bcyc, rv_seen);
        chk("init_len",   64'(cyc),  64'd1025);
        chk("busy_len",   64'(bcyc), 64'd1024);
        chk("init_no_rv", {63'd0, rv_seen}, 64'd0);

        rd("busy_wr_dropped", 12'd7,   64'd0);
        rd("zero_3ff",        12'h3FF, 64'd0);
        rd("zero_fff",        12'hFFF, 64'd0);
        tick();
        chk("rvalid_pulse", {63'd0, rvalid}, 64'd0);

        wr(12'd5, 8'hFF, 64'h1122334455667788);
        rd("full_word", 12'd5, 64'h1122334455667788);
        wr(12'd5, 8'h0F, 64'hAAAAAAAA_DEADBEEF);
        rd("merge_lo", 12'd5, 64'h11223344_DEADBEEF);
        wr(12'd5, 8'h80, 64'h99000000_00000000);
        rd("merge_hi", 12'd5, 64'h99223344_DEADBEEF);

        wr(12'h000, 8'hFF, 64'hA0A0A0A0_A0A0A0A0);
        wr(12'hC00, 8'hFF, 64'hC3C3C3C3_C3C3C3C3);
        wr(12'h400, 8'hFF, 64'hB1B1B1B1_B1B1B1B1);
        rd("row0", 12'h000, 64'hA0A0A0A0_A0A0A0A0);
        rd("row3", 12'hC00, 64'hC3C3C3C3_C3C3C3C3);
        rd("row1", 12'h400, 64'hB1B1B1B1_B1B1B1B1);
        rd("row2", 12'h800, 64'd0);

        // Write then read the same word on the very next cycle.
        en = 1'b1; we_s = 8'hFF; addr = 12'd9; di = 64'h0123456789ABCDEF;
        tick();
        we_s = '0;
        tick();
        en = 1'b0;
        chk("raw_rvalid", {63'd0, rvalid}, 64'd1);
        chk("raw_data",   dout, 64'h0123456789ABCDEF);

        for (int i = 0; i < 16; i++) wr(AW'(i), 8'hFF, pat(i));
        rv_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            en = 1'b1; we_s = '0; addr = AW'(i);
            tick();
            if (rvalid) rv_cnt++;
            chk($sformatf("stream_%0d", i), dout, pat(i));
        end
        en = 1'b0;
        tick();
        chk("stream_cnt", 64'(rv_cnt), 64'd16);
        chk("stream_end", {63'd0, rvalid}, 64'd0);

        // Reset while a read is returning.
        en = 1'b1; addr = 12'd3;
        tick();
        en = 1'b0;
        chk("pre_rst_rvalid", {63'd0, rvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("mid_rst_ready",  {63'd0, ready},  64'd0);
        chk("mid_rst_do",     dout,            64'd0);
        tick();
        rst_n = 1'b1;
        wait_ready(cyc, bcyc, rv_seen);
        chk("reinit_len",   64'(cyc),  64'd1025);
        chk("rebusy_len",   64'(bcyc), 64'd1024);
        chk("reinit_no_rv", {63'd0, rv_seen}, 64'd0);
        rd("rezero_5",   12'd5,   64'd0);
        rd("rezero_c00", 12'hC00, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
